// File: rtl/ahbl_sram_slave_if.sv
// rtl/ahbl_sram_slave_if.sv - AHB-Lite slave-side bus signals
interface ahbl_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// rtl/ahbl_sram_slave.sv - AHB-Lite word SRAM responder with fixed wait states
// and two-cycle ERROR response for out-of-range, oversized or misaligned beats.
module ahbl_sram_slave #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic              HCLK,
  input logic              HRESET,
  ahbl_sram_slave_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     offset;
  logic            accept, in_range, bad_size, misaligned, illegal, mem_we;
  logic [3:0]      be_c;
  logic            unused_bits;

  assign offset      = bus.HADDR - BASE_ADDR;
  assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign in_range    = (bus.HADDR >= BASE_ADDR) && ({1'b0, bus.HADDR} < END_ADDR);
  assign bad_size    = bus.HSIZE > 3'b010;
  assign misaligned  = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                       ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
  assign illegal     = !in_range || bad_size || misaligned;
  assign unused_bits = ^{bus.HTRANS[0], offset[31:AW+2], offset[1:0]};

  // Little-endian lane strobes; only meaningful for legal sizes
  always_comb begin
    be_c = 4'b1111;
    case (bus.HSIZE)
      3'b000:  be_c = 4'b0001 << bus.HADDR[1:0];
      3'b001:  be_c = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    be_d    = be_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all close with HREADYOUT high and may take a new beat
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = offset[AW+1:2];
          write_d = bus.HWRITE;
          be_d    = be_c;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  assign mem_we = (state_q == S_DATA) && write_q && !HRESET;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'h0;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb/tb_ahbl_sram_slave.sv - bench for ahbl_sram_slave with 1, 0 and 3 wait states
module tb_ahbl_sram_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  int          sel = 0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready_bus, hresp_bus;
  logic [31:0] hrdata_bus;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 hclk = ~hclk;

  ahbl_sram_slave_if b0 ();
  ahbl_sram_slave_if b1 ();
  ahbl_sram_slave_if b2 ();

  ahbl_sram_slave #(.DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(BASE)) u0 (.HCLK(hclk), .HRESET(hreset), .bus(b0));
  ahbl_sram_slave #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(BASE)) u1 (.HCLK(hclk), .HRESET(hreset), .bus(b1));
  ahbl_sram_slave #(.DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(BASE)) u2 (.HCLK(hclk), .HRESET(hreset), .bus(b2));

  assign hready_bus = (sel == 0) ? b0.HREADYOUT : (sel == 1) ? b1.HREADYOUT : b2.HREADYOUT;
  assign hresp_bus  = (sel == 0) ? b0.HRESP     : (sel == 1) ? b1.HRESP     : b2.HRESP;
  assign hrdata_bus = (sel == 0) ? b0.HRDATA    : (sel == 1) ? b1.HRDATA    : b2.HRDATA;

  assign b0.HSEL = hsel && (sel == 0);
  assign b1.HSEL = hsel && (sel == 1);
  assign b2.HSEL = hsel && (sel == 2);
  assign b0.HADDR = haddr;  assign b1.HADDR = haddr;  assign b2.HADDR = haddr;
  assign b0.HTRANS = htrans; assign b1.HTRANS = htrans; assign b2.HTRANS = htrans;
  assign b0.HWRITE = hwrite; assign b1.HWRITE = hwrite; assign b2.HWRITE = hwrite;
  assign b0.HSIZE = hsize;  assign b1.HSIZE = hsize;  assign b2.HSIZE = hsize;
  assign b0.HWDATA = hwdata; assign b1.HWDATA = hwdata; assign b2.HWDATA = hwdata;
  assign b0.HREADY = hready_bus; assign b1.HREADY = hready_bus; assign b2.HREADY = hready_bus;

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          ew;
    logic        er;
    logic [31:0] ed;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_pop(input string nm);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %h, expected <empty scoreboard>", nm, hrdata_bus);
    end else begin
      e = exp_q.pop_front();
      check(nm, hrdata_bus, e);
    end
  endtask

  // Waits for HREADYOUT at negedges; leaves the sampling point at the ready cycle.
  task automatic wait_ready(input string nm, output int waits, output logic first_resp);
    waits = 0;
    first_resp = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      if (i == 0) first_resp = hresp_bus;
      if (hready_bus) return;
      waits++;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout: HREADYOUT %b, expected 1", nm, hready_bus);
  endtask

  task automatic xfer(input vec_t v, input string nm);
    int   waits;
    logic fr;
    sel = v.s; hsel = 1'b1; htrans = 2'b10; hwrite = v.w; haddr = v.a; hsize = v.sz;
    exp_q.push_back(v.ed);
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0; hwdata = 32'hBAD0_BAD0;
    wait_ready(nm, waits, fr);
    check({nm, " waits"}, 32'(waits), 32'(v.ew));
    check({nm, " first resp"}, {31'b0, fr}, {31'b0, v.er});
    check({nm, " resp"}, {31'b0, hresp_bus}, {31'b0, v.er});
    check_pop({nm, " rdata"});
    hwdata = v.wd;
    @(posedge hclk); #1;
  endtask

  // Write then read with the read address presented during the write data phase.
  task automatic b2b(input int s, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [31:0] ra, input int ew, input logic [31:0] ed, input string nm);
    int   waits;
    logic fr;
    sel = s; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = wa; hsize = 3'b010;
    exp_q.push_back(32'h0);
    @(posedge hclk); #1;
    hwrite = 1'b0; haddr = ra; hwdata = 32'hBAD0_BAD0;
    exp_q.push_back(ed);
    wait_ready({nm, " wr"}, waits, fr);
    check({nm, " wr waits"}, 32'(waits), 32'(ew));
    check_pop({nm, " wr rdata"});
    hwdata = wd;
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0;
    wait_ready({nm, " rd"}, waits, fr);
    check({nm, " rd waits"}, 32'(waits), 32'(ew));
    check({nm, " rd resp"}, {31'b0, hresp_bus}, 32'h0);
    check_pop({nm, " rd rdata"});
    @(posedge hclk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Table: sel, write, addr, size, wdata (bus lanes), waits, resp, final HRDATA
    vt.push_back('{0, 1'b1, BASE + 32'h10,  3'b010, 32'hDEAD_BEEF, 1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h10,  3'b010, 32'h0,         1, 1'b0, 32'hDEAD_BEEF});
    vt.push_back('{0, 1'b1, BASE + 32'h13,  3'b000, 32'hA500_0000, 1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h10,  3'b010, 32'h0,         1, 1'b0, 32'hA5AD_BEEF});
    vt.push_back('{0, 1'b1, BASE + 32'h12,  3'b001, 32'h1234_0000, 1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h10,  3'b010, 32'h0,         1, 1'b0, 32'h1234_BEEF});
    vt.push_back('{0, 1'b0, BASE + 32'h400, 3'b010, 32'h0,         1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h1,   3'b001, 32'h0,         1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b1, BASE + 32'h11,  3'b001, 32'hFFFF_FFFF, 1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b1, BASE + 32'h10,  3'b011, 32'hFFFF_FFFF, 1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b0, BASE - 32'h4,   3'b010, 32'h0,         1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b1, BASE + 32'h12,  3'b010, 32'hFFFF_FFFF, 1, 1'b1, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h10,  3'b010, 32'h0,         1, 1'b0, 32'h1234_BEEF});
    vt.push_back('{0, 1'b1, BASE + 32'h3FC, 3'b010, 32'h0BAD_F00D, 1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b1, BASE + 32'h3FF, 3'b000, 32'h7700_0000, 1, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, BASE + 32'h3FC, 3'b010, 32'h0,         1, 1'b0, 32'h77AD_F00D});
    vt.push_back('{0, 1'b0, BASE + 32'h3FD, 3'b000, 32'h0,         1, 1'b0, 32'h77AD_F00D});
    vt.push_back('{2, 1'b1, BASE + 32'h20,  3'b010, 32'hCAFE_0001, 3, 1'b0, 32'h0});
    vt.push_back('{2, 1'b0, BASE + 32'h20,  3'b010, 32'h0,         3, 1'b0, 32'hCAFE_0001});
    vt.push_back('{1, 1'b1, BASE + 32'h4,   3'b010, 32'h2222_2222, 0, 1'b0, 32'h0});
    vt.push_back('{1, 1'b0, BASE + 32'h4,   3'b010, 32'h0,         0, 1'b0, 32'h2222_2222});
    vt.push_back('{1, 1'b0, BASE + 32'h400, 3'b010, 32'h0,         1, 1'b1, 32'h0});

    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    check("rst u0 ready", {31'b0, b0.HREADYOUT}, 32'h1);
    check("rst u0 resp",  {31'b0, b0.HRESP}, 32'h0);
    check("rst u0 rdata", b0.HRDATA, 32'h0);
    check("rst u1 ready", {31'b0, b1.HREADYOUT}, 32'h1);
    check("rst u2 ready", {31'b0, b2.HREADYOUT}, 32'h1);
    check("rst u2 rdata", b2.HRDATA, 32'h0);
    @(posedge hclk); #1;

    foreach (vt[i]) xfer(vt[i], $sformatf("vec%0d", i));

    b2b(1, BASE + 32'h0, 32'h1111_1111, BASE + 32'h0, 0, 32'h1111_1111, "b2b ws0");
    b2b(0, BASE + 32'h8, 32'h3333_4444, BASE + 32'h8, 1, 32'h3333_4444, "b2b ws1");

    // Reset during the second wait cycle of a WAIT_STATES=3 write
    xfer('{2, 1'b1, BASE + 32'h30, 3'b010, 32'h0000_AAAA, 3, 1'b0, 32'h0}, "rst old wr");
    sel = 2; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h30; hsize = 3'b010;
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0; hwdata = 32'h5555_5555;
    @(negedge hclk);
    check("rst wait1 ready", {31'b0, hready_bus}, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(negedge hclk);
    check("rst wait2 ready", {31'b0, hready_bus}, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("rst after ready", {31'b0, hready_bus}, 32'h1);
    check("rst after resp",  {31'b0, hresp_bus}, 32'h0);
    check("rst after rdata", hrdata_bus, 32'h0);
    @(posedge hclk); #1;
    xfer('{2, 1'b0, BASE + 32'h30, 3'b010, 32'h0, 3, 1'b0, 32'h0000_AAAA}, "rst old rd");

    // BUSY then IDLE with HSEL high, then NONSEQ with HSEL low: no transfer
    sel = 0; hsel = 1'b1; hwrite = 1'b1; haddr = BASE + 32'h10; hsize = 3'b010; hwdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      htrans = (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : 2'b10;
      hsel = (k < 2);
      for (int c = 0; c < 2; c++) begin
        @(posedge hclk); #1;
        @(negedge hclk);
        check($sformatf("notr%0d ready", k), {31'b0, hready_bus}, 32'h1);
        check($sformatf("notr%0d resp", k),  {31'b0, hresp_bus}, 32'h0);
        check($sformatf("notr%0d rdata", k), hrdata_bus, 32'h0);
      end
    end
    @(posedge hclk); #1;
    htrans = 2'b00; hsel = 1'b0;
    @(posedge hclk); #1;
    xfer('{0, 1'b0, BASE + 32'h10, 3'b010, 32'h0, 1, 1'b0, 32'h1234_BEEF}, "notr mem");

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahbl_sram_slave.md
Name: ahbl_sram_slave

Overview:
- AHB-Lite responder at the slave end of the bus mux, after master arbitration and address decode.
- Single-ported, word-organised on-chip memory with a fixed number of wait states per transfer.
- Returns the two-cycle ERROR response for illegal transfers.
- Ties a memory region to the bus with correct data-phase pipelining so arbiter and mux handover can be exercised against a realistic stalling slave.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 2.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted before every OKAY data phase; 0 is legal.
- BASE_ADDR, 32'h0000_0000, byte base of the region; aligned to DEPTH*4.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready (mux output).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (HRESET=1 at a HCLK edge):
  - State goes to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0; wait counter cleared.
  - Memory contents are retained, not cleared.
  - Reset mid-transfer abandons the transfer; no write is committed.
- Address phase accepted on a HCLK edge iff HSEL & HREADY & HTRANS[1]. Capture HADDR, HWRITE and HSIZE.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no transfer; the next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Illegal transfer, flagged at capture:
  - HADDR outside [BASE_ADDR, BASE_ADDR+DEPTH*4);
  - HSIZE > 010;
  - misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]≠0.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - On accept, illegal → ERR1.
    - Legal with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
    - Legal with WAIT_STATES=0 → DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0. Final data-phase cycle of a legal transfer.
    - Read: HRDATA = mem[word index] (full word, all lanes) combinationally in this cycle.
    - Write: selected byte lanes of HWDATA written to mem at the closing edge. Lanes are little-endian from HADDR[1:0] and HSIZE.
    - Same edge may accept a new address phase (back-to-back pipelining), taking the IDLE transitions; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; no write → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new transfer may be accepted here (same rules as IDLE); otherwise → IDLE.
- No address phase is sampled in WAIT or ERR1, because HREADY is low.
- HRDATA is 0 in every cycle except a read DATA cycle.
- Hazard: a write committed in DATA is visible to a read accepted on that same edge, including with WAIT_STATES=0.
- HWDATA is sampled only on the DATA closing edge; values during WAIT are ignored.
- Word index is (HADDR-BASE_ADDR)[$clog2(DEPTH)+1:2]. The top word and last byte lane are legal; BASE_ADDR+DEPTH*4 is an error.
- HMASTLOCK and HBURST are not used; each beat is handled independently.

Test Plan:
- WAIT_STATES=1: word write 32'hDEAD_BEEF at BASE+0x10, then read it → write DATA phase preceded by exactly 1 HREADYOUT=0 cycle; read returns 32'hDEAD_BEEF, HRESP=0.
- Byte write 8'hA5 at BASE+0x13, then word read of BASE+0x10 → 32'hA5AD_BEEF; halfword write 16'h1234 at BASE+0x12 → read 32'h1234_BEEF.
- Word read at BASE+DEPTH*4 and halfword at BASE+0x1 → each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles; memory unchanged; HRDATA=0.
- WAIT_STATES=0: back-to-back NONSEQ write 0x1111_1111 @0x0 then read @0x0 → zero wait; read returns 0x1111_1111 the cycle after the write DATA cycle.
- WAIT_STATES=3: HRESET asserted in the second WAIT cycle of a write → next cycle HREADYOUT=1, HRESP=0, HRDATA=0; a later read of that address returns the old value.
- HTRANS=BUSY, then IDLE, with HSEL=1 → HREADYOUT stays 1, HRESP=0, no memory change.
